// File: rtl/emitter_uart.sv
// emitter_uart
//   Transmit-only 8N1 UART used as the SoC console output. Bytes written
//   through the IO write path are buffered in a small FIFO. A frame FSM
//   serialises them LSB first at baud_rate. The bit period is DIV clock
//   cycles, derived from clk_freq_hz by rounding to the nearest integer.
//
// Parameters
//   clk_freq_hz : input clock frequency in Hz
//   baud_rate   : serial bit rate
//   FIFO_DEPTH  : byte buffer entries (power of two, >= 2)
//
// Ports
//   i_clk     : clock, all flops on the rising edge
//   i_rst     : asynchronous active-high reset
//   i_data    : byte to transmit
//   i_valid   : write strobe, one cycle per byte
//   o_ready   : registered "FIFO not full"; a write is taken only when high
//   o_uart_tx : serial line, idle high, driven directly from a flop
module emitter_uart #(
  parameter int clk_freq_hz = 50000000,
  parameter int baud_rate   = 230400,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx
);

  localparam int DIV = (clk_freq_hz + baud_rate / 2) / baud_rate;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and pointers (one extra MSB to tell full from empty)
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        ready_q;

  // Transmitter state
  state_t      state_q;
  logic        tx_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;

  logic empty;
  logic full_d;
  logic push;
  logic pop;
  logic bit_done;

  always_comb begin
    empty    = (wptr_q == rptr_q);
    // Acceptance uses the registered ready, so a write that coincides with a
    // pop from a full FIFO is still dropped.
    push     = i_valid & ready_q;
    bit_done = (cnt_q == '0);
    // The FSM takes a byte either from IDLE or at the last cycle of a stop
    // bit, which is what keeps back-to-back frames contiguous.
    pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
    wptr_d   = wptr_q + (AW + 1)'(push);
    rptr_d   = rptr_q + (AW + 1)'(pop);
    full_d   = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  // Storage has no reset so it can map onto plain memory.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= !full_d;
    end
  end

  // Frame FSM. The line level is registered together with each state change,
  // so every bit lasts exactly DIV cycles (cnt_q counts DIV-1 down to 0).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
            cnt_q   <= CNT_RELOAD;
            shift_q <= mem_q[rptr_q[AW-1:0]];
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= '0;
            cnt_q   <= CNT_RELOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= CNT_RELOAD;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
              cnt_q   <= CNT_RELOAD;
              shift_q <= mem_q[rptr_q[AW-1:0]];
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_emitter_uart.sv
// tb_emitter_uart
//   Directed bench for emitter_uart. dut1 runs at the default parameters.
//   A line monitor checks every cycle of each frame against the byte at the
//   head of a scoreboard queue. dut2 runs at DIV=10 and is checked inline.
module tb_emitter_uart;

  localparam int DIV  = 217;
  localparam int DIV2 = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, ready2;
  logic       tx1, tx2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] sb[$];
  int         starts[$];
  bit         mon_en   = 1'b0;
  bit         mon_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  emitter_uart dut1 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data1),
    .i_valid  (valid1),
    .o_ready  (ready1),
    .o_uart_tx(tx1)
  );

  emitter_uart #(
    .clk_freq_hz(1000),
    .baud_rate  (100),
    .FIFO_DEPTH (4)
  ) dut2 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data2),
    .i_valid  (valid2),
    .o_ready  (ready2),
    .o_uart_tx(tx2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One write strobe to dut1, starting and ending on a falling edge.
  task automatic drive1(input logic [7:0] d, input logic exp_rdy, input string tag);
    check(tag, 32'(ready1), 32'(exp_rdy));
    data1  = d;
    valid1 = 1'b1;
    if (exp_rdy) sb.push_back(d);
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb.size() != 0 || mon_busy), 32'd0);
  endtask

  // Line monitor for dut1
  initial begin : monitor
    logic [7:0] exp_b;
    logic [9:0] lvl;
    logic [9:0] dec;
    int         bad;
    forever begin
      @(negedge clk);
      if (mon_en && tx1 === 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        check("frame_expected", 32'(sb.size() > 0), 32'd1);
        exp_b = 8'h00;
        if (sb.size() > 0) exp_b = sb.pop_front();
        lvl = {1'b1, exp_b, 1'b0};
        bad = 0;
        dec = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < DIV; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (tx1 !== lvl[b]) bad++;
            if (c == DIV / 2) dec[b] = tx1;
          end
        end
        if (mon_en) begin
          check("frame_levels", 32'(bad), 32'd0);
          check("frame_byte", 32'(dec[8:1]), 32'(exp_b));
          check("frame_stop", 32'(dec[9]), 32'd1);
          $display("frame byte=0x%02h decoded=0x%02h bad_cycles=%0d", exp_b, dec[8:1], bad);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stim
    int n;
    int lows;
    int bad;
    logic [9:0] lvl2;

    rst    = 1'b1;
    valid1 = 1'b0;
    data1  = 8'h00;
    valid2 = 1'b0;
    data2  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx1), 32'd1);
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_tx2", 32'(tx2), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx", 32'(tx1), 32'd1);
    check("post_rst_ready", 32'(ready1), 32'd1);
    mon_en = 1'b1;

    // Single byte, start edge within 3 cycles of acceptance
    drive1(8'h41, 1'b1, "single_ready");
    n = 0;
    while (tx1 !== 1'b0 && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("single_start_le3", 32'(tx1), 32'd0);
    $display("single 0x41 start seen %0d negedges after accept", n + 1);
    wait_idle("single_timeout", 3000);

    // Burst of three contiguous frames
    starts.delete();
    drive1(8'h48, 1'b1, "burst_ready0");
    drive1(8'h69, 1'b1, "burst_ready1");
    drive1(8'h0A, 1'b1, "burst_ready2");
    wait_idle("burst_timeout", 8000);
    check("burst_frames", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      check("burst_gap0", 32'(starts[1] - starts[0]), 32'(10 * DIV));
      check("burst_gap1", 32'(starts[2] - starts[1]), 32'(10 * DIV));
    end

    // Overflow: depth 4 plus the byte already in the shifter, sixth dropped
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      drive1(8'(i), (i < 5), $sformatf("ovf_ready%0d", i));
    end
    // Stall hold: write while full must be ignored
    drive1(8'hFF, 1'b0, "stall_ready");
    n = 0;
    while (starts.size() < 2 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    check("stall_next_start", 32'(starts.size() >= 2), 32'd1);
    check("stall_ready_back", 32'(ready1), 32'd1);
    wait_idle("ovf_timeout", 12000);
    check("ovf_frames", 32'(starts.size()), 32'd5);

    // Asynchronous reset mid-frame with a full FIFO
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive1(8'h00, 1'b1, $sformatf("rstfill_ready%0d", i));
    end
    sb.delete();
    check("rstfill_full", 32'(ready1), 32'd0);
    repeat (500) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx1), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx1), 32'd1);
    check("async_rst_ready", 32'(ready1), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    check("rst_hold_high", 32'(lows), 32'd0);
    check("rst_hold_ready", 32'(ready1), 32'd1);
    $display("reset mid-frame: low cycles in 5000 after release=%0d", lows);
    mon_en = 1'b1;

    // Parameter sweep: DIV=10, byte 0xA5
    lvl2 = 10'b11_0100_1010;  // levels in time order 0,1,0,1,0,0,1,0,1,1 (bit0 first)
    data2  = 8'hA5;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    n = 0;
    while (tx2 !== 1'b0 && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("p_start_le3", 32'(tx2), 32'd0);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < DIV2; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx2 !== lvl2[b]) bad++;
      end
      check($sformatf("p_bit%0d", b), 32'(bad), 32'd0);
    end
    @(negedge clk);
    check("p_idle_after", 32'(tx2), 32'd1);
    $display("param sweep 0xA5 frame checked over %0d cycles", 10 * DIV2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
